prefetch_fetch_unit: RTL and testbench
======================================

// Module: prefetch_fetch_unit
// PURPOSE
//   Parametrised successor to fetch_stm: decouples instruction fetch from execute. Issues pipelined
//   Wishbone B4 reads ahead of the core, buffers {pc, ir, err} in a DEPTH-entry FIFO, presents them
//   via valid/ready, and flushes on redirect (taken branch/jump) discarding in-flight responses.
// PARAMETERS
//   DEPTH            4             FIFO entries; power of 2, >=2
//   MAX_OUTSTANDING  2             max accepted-but-unacked bus requests; 1..DEPTH
//   RESET_PC         32'h0000_0000 first fetch address; bits[1:0] must be 0
// PORTS
//   clk          in   1   clock
//   rst          in   1   asynchronous, active-low reset
//   wb_cyc_o     out  1   Wishbone cycle
//   wb_stb_o     out  1   Wishbone strobe (pipelined mode)
//   wb_adr_o     out  32  fetch byte address, word aligned
//   wb_dat_i     in   32  instruction read data
//   wb_ack_i     in   1   read acknowledge
//   wb_err_i     in   1   bus error (terminates request like ack)
//   wb_stall_i   in   1   slave cannot accept request this cycle
//   redirect     in   1   jump/branch taken: flush and refetch
//   redirect_pc  in   32  new fetch address; bits[1:0] ignored (treated as 0)
//   out_valid    out  1   FIFO head valid
//   out_ready    in   1   core consumes head
//   out_pc       out  32  pc of head instruction
//   out_ir       out  32  head instruction
//   out_err      out  1   head fetch ended in wb_err_i
// BEHAVIOUR
// - Reset (rst=0, async): FIFO empty, out_valid=0, out_pc/out_ir=0, out_err=0, wb_cyc_o=0,
//   wb_stb_o=0, wb_adr_o=RESET_PC, fetch_pc=RESET_PC, outstanding=0, discard=0, halted=0.
// - Issue: wb_stb_o=1 iff !halted && !redirect && outstanding<MAX_OUTSTANDING &&
//   (fifo_count+outstanding)<DEPTH. Accept = stb && !stall: fetch_pc+=4, outstanding++.
//   While stalled, wb_adr_o and wb_stb_o held stable; wb_adr_o==fetch_pc always.
// - wb_cyc_o = wb_stb_o || outstanding!=0. Deasserted when idle.
// - Response (ack|err): outstanding--. If discard!=0: discard--, data dropped. Else push
//   {resp_pc, dat_i, err}; resp_pc+=4. Reservation rule guarantees push never overflows.
// - err pushed: halted=1, no further issue until redirect; remaining responses still pushed.
// - Output: out_* driven from FIFO head (registered storage); pop when out_valid&&out_ready.
//   Push and pop same cycle legal at any count. Latency: ack cycle N -> out_valid at N+1.
// - Redirect (single cycle): FIFO cleared (out_valid=0 next cycle), pop ignored, stb=0 that cycle,
//   fetch_pc=resp_pc={redirect_pc[31:2],2'b00}, halted=0,
//   discard = outstanding + accept_this_cycle(0, stb low) - (ack|err this cycle ? 1:0) if discard
//   was 0; otherwise discard stays the count of all unacked requests. Issue resumes next cycle.
// - Redirect has priority over push, pop and err-halt in the same cycle.
// - pc arithmetic mod 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
// - Response with no outstanding request: ignored (assertion fires in sim).
// - rst mid-transaction: cyc/stb drop immediately; slave must tolerate abandoned cycle.
// TESTING
// 1. RESET_PC=0x100, zero-wait slave (ack next cycle), out_ready=1 -> out_pc 0x100,0x104,0x108...
//    in order with matching IR, one per cycle in steady state when MAX_OUTSTANDING>=2.
// 2. out_ready=0, DEPTH=4 -> exactly 4 entries buffered, stb low, count+outstanding<=4; then
//    out_ready=1 -> all 4 drained in order, no loss or duplicate.
// 3. 2 requests outstanding, redirect to 0x2000 -> both acks dropped, next out_pc=0x2000;
//    repeat with ack in the redirect cycle -> still no stale entry.
// 4. wb_stall_i held 3 cycles on 0x104 -> adr stays 0x104, exactly one accept, no skip.
// 5. err on 0x108 -> entry 0x108 has out_err=1, stb stays low; redirect 0x300 -> fetch resumes.
// 6. redirect to 0xFFFF_FFF9 -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst low mid-burst
//    -> next cycle cyc=0, out_valid=0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/prefetch_fetch_unit.sv
// Instruction prefetch unit: issues pipelined Wishbone reads ahead of the core,
// buffers {pc, ir, err} in a small FIFO and flushes on redirect, dropping any
// responses that belong to requests issued before the redirect.
module prefetch_fetch_unit #(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic [31:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_stall_i,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_ir,
   output logic        out_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

   logic          run_q,     run_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q,  resp_pc_d;
   logic [CW-1:0] outs_q,    outs_d;
   logic [CW-1:0] discard_q, discard_d;
   logic          halted_q,  halted_d;
   logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
   logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
   logic [CW-1:0] count_q,   count_d;

   logic [31:0]   mem_pc  [DEPTH];
   logic [31:0]   mem_ir  [DEPTH];
   logic          mem_err [DEPTH];

   logic          resp;
   logic          room;
   logic          stb;
   logic          accept;
   logic          push;
   logic          pop;
   logic [31:0]   redirect_al;

   // Issue/response qualifiers; the reservation check counts both buffered
   // entries and in-flight requests so a push can never find the FIFO full.
   always_comb begin
      redirect_al = redirect_pc & ~32'h3;
      resp        = (wb_ack_i || wb_err_i) && (outs_q != '0);
      room        = ({1'b0, count_q} + {1'b0, outs_q}) < {1'b0, DEPTH_C};
      stb         = run_q && !halted_q && !redirect && (outs_q < MAX_C) && room;
      accept      = stb && !wb_stall_i;
      push        = resp && (discard_q == '0) && !redirect;
      pop         = (count_q != '0) && out_ready && !redirect;
   end

   // Next-state for fetch/response tracking and FIFO pointers; redirect wins
   // over every other update in the same cycle.
   always_comb begin
      run_d      = 1'b1;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outs_d     = outs_q + CW'(accept) - CW'(resp);
      discard_d  = discard_q;
      halted_d   = halted_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = redirect_al;
         resp_pc_d  = redirect_al;
         // stb is low this cycle, so every request still unacked after this
         // edge belongs to the old stream and must be dropped.
         discard_d  = outs_q - CW'(resp);
         halted_d   = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (resp && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + PW'(1);
            if (wb_err_i) begin
               halted_d = 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q      <= 1'b0;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outs_q     <= '0;
         discard_q  <= '0;
         halted_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         run_q      <= run_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outs_q     <= outs_d;
         discard_q  <= discard_d;
         halted_q   <= halted_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; contents need no reset because the outputs are gated by valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr_q]  <= resp_pc_q;
         mem_ir[wr_ptr_q]  <= wb_dat_i;
         mem_err[wr_ptr_q] <= wb_err_i;
      end
   end

   // Bus and head-of-FIFO outputs.
   always_comb begin
      wb_stb_o  = stb;
      wb_cyc_o  = stb || (outs_q != '0);
      wb_adr_o  = fetch_pc_q;
      out_valid = (count_q != '0);
      out_pc    = out_valid ? mem_pc[rd_ptr_q]  : 32'h0;
      out_ir    = out_valid ? mem_ir[rd_ptr_q]  : 32'h0;
      out_err   = out_valid ? mem_err[rd_ptr_q] : 1'b0;
   end

   resp_has_request: assert property (@(posedge clk) disable iff (!rst)
      (wb_ack_i || wb_err_i) |-> (outs_q != '0));

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Directed bench for prefetch_fetch_unit with a zero-wait pipelined slave model.
module tb_prefetch_fetch_unit;

   logic        clk;
   logic        rst;
   logic        wb_cyc_o, wb_stb_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i, wb_err_i, wb_stall_i;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_ir;
   logic        out_err;

   int          checks = 0;
   int          errors = 0;

   logic        hold;
   logic [31:0] err_addr;
   logic [31:0] pend [$];

   prefetch_fetch_unit #(
      .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0100)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
      .wb_stall_i(wb_stall_i),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_ir(out_ir), .out_err(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic        exp_stb;
      logic [31:0] exp_adr;
      logic        exp_cyc;
   } vec_t;

   vec_t tv [15];

   function automatic logic [31:0] insn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: latch the request seen before the edge, then drive the slave response.
   task automatic step();
      logic        acc;
      logic [31:0] a;
      logic [31:0] r;
      acc = rst && wb_stb_o && !wb_stall_i;
      a   = wb_adr_o;
      @(posedge clk);
      #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (!rst) begin
         pend.delete();
      end else begin
         if (acc) pend.push_back(a);
         if (!hold && pend.size() > 0) begin
            r        = pend.pop_front();
            wb_dat_i = insn(r);
            if (r == err_addr) wb_err_i = 1'b1;
            else               wb_ack_i = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      rst        = 1'b0;
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      pend.delete();
      redirect   = 1'b0;
      wb_stall_i = 1'b0;
      hold       = 1'b0;
      out_ready  = 1'b0;
      err_addr   = 32'h1;
      step();
      step();
      chk("rst_cyc",   32'(wb_cyc_o),  32'h0);
      chk("rst_stb",   32'(wb_stb_o),  32'h0);
      chk("rst_adr",   wb_adr_o,       32'h100);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_pc",    out_pc,         32'h0);
      chk("rst_ir",    out_ir,         32'h0);
      chk("rst_err",   32'(out_err),   32'h0);
      rst = 1'b1;
   endtask

   // Consume n entries with out_ready high and check them against a linear pc stream.
   task automatic expect_stream(input logic [31:0] start, input int n, input int budget);
      logic [31:0] exp;
      int          got;
      exp       = start;
      got       = 0;
      out_ready = 1'b1;
      #1;
      for (int c = 0; c < budget && got < n; c++) begin
         if (out_valid) begin
            chk("stream_pc",  out_pc,         exp);
            chk("stream_ir",  out_ir,         insn(exp));
            chk("stream_err", 32'(out_err),   32'(exp == err_addr));
            exp = exp + 32'd4;
            got++;
         end
         step();
         #1;
      end
      chk("stream_count", 32'(got), 32'(n));
   endtask

   initial begin
      rst         = 1'b0;
      wb_dat_i    = 32'h0;
      redirect_pc = 32'h0;

      //            rdy   valid pc            stb   adr            cyc
      tv[0]  = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h100, 1'b1};
      tv[1]  = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h104, 1'b1};
      tv[2]  = '{1'b1, 1'b1, 32'h100,  1'b1, 32'h108, 1'b1};
      tv[3]  = '{1'b1, 1'b1, 32'h104,  1'b1, 32'h10C, 1'b1};
      tv[4]  = '{1'b0, 1'b1, 32'h108,  1'b1, 32'h110, 1'b1};
      tv[5]  = '{1'b0, 1'b1, 32'h108,  1'b1, 32'h114, 1'b1};
      tv[6]  = '{1'b0, 1'b1, 32'h108,  1'b0, 32'h118, 1'b1};
      tv[7]  = '{1'b0, 1'b1, 32'h108,  1'b0, 32'h118, 1'b0};
      tv[8]  = '{1'b1, 1'b1, 32'h108,  1'b0, 32'h118, 1'b0};
      tv[9]  = '{1'b1, 1'b1, 32'h10C,  1'b1, 32'h118, 1'b1};
      tv[10] = '{1'b1, 1'b1, 32'h110,  1'b1, 32'h11C, 1'b1};
      tv[11] = '{1'b1, 1'b1, 32'h114,  1'b1, 32'h120, 1'b1};
      tv[12] = '{1'b1, 1'b1, 32'h118,  1'b1, 32'h124, 1'b1};
      tv[13] = '{1'b1, 1'b1, 32'h11C,  1'b1, 32'h128, 1'b1};
      tv[14] = '{1'b1, 1'b1, 32'h120,  1'b1, 32'h12C, 1'b1};

      // Streaming, back-pressure to a full FIFO, then drain.
      do_reset();
      for (int k = 0; k < 15; k++) begin
         step();
         out_ready = tv[k].rdy;
         #1;
         chk("tv_valid", 32'(out_valid), 32'(tv[k].exp_valid));
         chk("tv_stb",   32'(wb_stb_o),  32'(tv[k].exp_stb));
         chk("tv_adr",   wb_adr_o,       tv[k].exp_adr);
         chk("tv_cyc",   32'(wb_cyc_o),  32'(tv[k].exp_cyc));
         if (tv[k].exp_valid) begin
            chk("tv_pc",  out_pc,       tv[k].exp_pc);
            chk("tv_ir",  out_ir,       insn(tv[k].exp_pc));
            chk("tv_err", 32'(out_err), 32'h0);
         end
      end

      // Redirect with two requests in flight; both responses must be dropped.
      do_reset();
      hold      = 1'b1;
      out_ready = 1'b1;
      step(); #1;
      chk("r1_adr0", wb_adr_o, 32'h100);
      step(); #1;
      chk("r1_adr1", wb_adr_o, 32'h104);
      step(); #1;
      chk("r1_stb_max", 32'(wb_stb_o), 32'h0);
      chk("r1_cyc_out", 32'(wb_cyc_o), 32'h1);
      redirect    = 1'b1;
      redirect_pc = 32'h2000;
      #1;
      chk("r1_stb_redir", 32'(wb_stb_o), 32'h0);
      hold = 1'b0;
      step();
      redirect = 1'b0;
      #1;
      chk("r1_valid_after", 32'(out_valid), 32'h0);
      chk("r1_adr_new",     wb_adr_o,       32'h2000);
      expect_stream(32'h2000, 2, 20);

      // Same, but one ack lands in the redirect cycle itself.
      do_reset();
      hold      = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      hold = 1'b0;
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h2000;
      #1;
      step();
      redirect = 1'b0;
      #1;
      chk("r2_valid_after", 32'(out_valid), 32'h0);
      expect_stream(32'h2000, 2, 20);

      // Stall held for three edges on 0x104, then a redirect while stb would be high.
      do_reset();
      step(); #1;
      chk("st_adr0", wb_adr_o, 32'h100);
      step();
      wb_stall_i = 1'b1;
      #1;
      chk("st_adr_a", wb_adr_o, 32'h104);
      chk("st_stb_a", 32'(wb_stb_o), 32'h1);
      step(); #1;
      chk("st_adr_b", wb_adr_o, 32'h104);
      chk("st_stb_b", 32'(wb_stb_o), 32'h1);
      step(); #1;
      chk("st_adr_c", wb_adr_o, 32'h104);
      chk("st_stb_c", 32'(wb_stb_o), 32'h1);
      step();
      wb_stall_i = 1'b0;
      #1;
      chk("st_adr_d", wb_adr_o, 32'h104);
      expect_stream(32'h100, 4, 30);
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      #1;
      chk("st_stb_redir", 32'(wb_stb_o), 32'h0);
      step();
      redirect = 1'b0;
      #1;
      expect_stream(32'h40, 2, 20);

      // Bus error on 0x108: flagged entry, issue halts until redirect.
      do_reset();
      err_addr = 32'h108;
      expect_stream(32'h100, 4, 30);
      for (int k = 0; k < 3; k++) begin
         chk("er_stb_halt", 32'(wb_stb_o), 32'h0);
         chk("er_cyc_idle", 32'(wb_cyc_o), 32'h0);
         step(); #1;
      end
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      err_addr    = 32'h1;
      #1;
      step();
      redirect = 1'b0;
      #1;
      chk("er_adr_resume", wb_adr_o,       32'h300);
      chk("er_stb_resume", 32'(wb_stb_o),  32'h1);
      expect_stream(32'h300, 3, 20);

      // Fill FIFO, redirect to an unaligned pc near the top, wrap, then reset mid-burst.
      do_reset();
      for (int k = 0; k < 8; k++) step();
      #1;
      chk("wr_full_valid", 32'(out_valid), 32'h1);
      chk("wr_full_pc",    out_pc,         32'h100);
      chk("wr_full_stb",   32'(wb_stb_o),  32'h0);
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF9;
      out_ready   = 1'b1;
      #1;
      step();
      redirect = 1'b0;
      #1;
      chk("wr_flush_valid", 32'(out_valid), 32'h0);
      chk("wr_adr_align",   wb_adr_o,       32'hFFFF_FFF8);
      expect_stream(32'hFFFF_FFF8, 3, 20);
      rst      = 1'b0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      pend.delete();
      #1;
      chk("mr_cyc",   32'(wb_cyc_o),  32'h0);
      chk("mr_stb",   32'(wb_stb_o),  32'h0);
      chk("mr_valid", 32'(out_valid), 32'h0);
      chk("mr_adr",   wb_adr_o,       32'h100);
      step();
      step();
      rst = 1'b1;
      expect_stream(32'h100, 2, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
